// File: rtl/zxuno_option_bank.sv
`default_nettype none
//==============================================================================
//  Module   : zxuno_option_bank
//  Purpose  : Bank of NREGS 8-bit option registers mapped into the ZX-Uno
//             register space at BASE_ADDR..BASE_ADDR+NREGS-1 (modulo 256),
//             with an optional write-lock state machine behind LOCK_ADDR.
//
//  Ports    : clk          system clock, rising edge
//             rst_n        synchronous active-low reset
//             zxuno_addr   register-space address
//             zxuno_regrd  read strobe (level)
//             zxuno_regwr  write strobe (level, only its rising edge writes)
//             din          write data
//             dout         read data (combinational, 8'hFF when not driven)
//             oe_n         active-low read-data enable (combinational)
//             options      live register contents, byte k = register k
//             opt_changed  one-cycle pulse per register whose value changed
//             locked       high while the lock FSM is LOCKED or KEY1
//
//  Build    : define OPTBANK_LOCK_EN to compile in the lock FSM and the
//             LOCK_ADDR decode; otherwise the bank is always writable and
//             LOCK_ADDR reads as unmapped.
//
//  Revision : 1.0  initial release
//==============================================================================
module zxuno_option_bank #(
    parameter int                 NREGS       = 2,
    parameter logic [7:0]         BASE_ADDR   = 8'h0E,
    parameter logic [8*NREGS-1:0] RESET_VALUE = '0,
    parameter logic [7:0]         LOCK_ADDR   = 8'h0D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         zxuno_addr,
    input  logic               zxuno_regrd,
    input  logic               zxuno_regwr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               oe_n,
    output logic [8*NREGS-1:0] options,
    output logic [NREGS-1:0]   opt_changed,
    output logic               locked
);

    localparam logic [8:0] c_NREGS = 9'(NREGS);

    logic       r_wr_d;
    logic       w_wr_accept;
    logic [7:0] w_off;
    logic       w_in_bank;
    logic       w_lock_hit;
    logic       w_unlocked;
    logic       w_bank_hit;
    logic       w_wr_bank;
    logic [7:0] w_state_rd;
    logic [7:0] w_rd_val;

    // Write-strobe history. Reset loads 1 so a strobe that is already high
    // when reset is released is treated as "seen" and is not accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_d <= 1'b1;
        end else begin
            r_wr_d <= zxuno_regwr;
        end
    end

    assign w_wr_accept = zxuno_regwr & ~r_wr_d;

    // Offset into the bank; 8-bit subtraction wraps modulo 256 naturally.
    assign w_off     = zxuno_addr - BASE_ADDR;
    assign w_in_bank = ({1'b0, w_off} < c_NREGS);

`ifdef OPTBANK_LOCK_EN
    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_LOCKED   = 2'd1;
    localparam logic [1:0] c_ST_KEY1     = 2'd2;

    logic [1:0] r_state;

    assign w_lock_hit = (zxuno_addr == LOCK_ADDR);
    assign w_unlocked = (r_state == c_ST_UNLOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_UNLOCKED;
        end else if (w_wr_accept) begin
            case (r_state)
                c_ST_UNLOCKED: begin
                    if (w_lock_hit && din == 8'hFF) r_state <= c_ST_LOCKED;
                end
                c_ST_LOCKED: begin
                    if (w_lock_hit && din == 8'hA5) r_state <= c_ST_KEY1;
                end
                c_ST_KEY1: begin
                    // Any accepted write other than the second key re-locks.
                    if (w_lock_hit && din == 8'h5A) r_state <= c_ST_UNLOCKED;
                    else                            r_state <= c_ST_LOCKED;
                end
                default: r_state <= c_ST_LOCKED;
            endcase
        end
    end

    assign locked     = ~w_unlocked;
    assign w_state_rd = {6'b0, r_state};
`else
    logic w_unused_lock_addr;

    assign w_lock_hit         = 1'b0;
    assign w_unlocked         = 1'b1;
    assign locked             = 1'b0;
    assign w_state_rd         = 8'hFF;
    assign w_unused_lock_addr = &{1'b0, LOCK_ADDR};
`endif

    // The lock address wins over an overlapping bank slot.
    assign w_bank_hit = w_in_bank & ~w_lock_hit;
    assign w_wr_bank  = w_wr_accept & w_bank_hit & w_unlocked;

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_reg
            localparam logic [7:0] c_K = 8'(k);

            logic [7:0] r_val;
            logic       r_chg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_val <= RESET_VALUE[8*k +: 8];
                    r_chg <= 1'b0;
                end else begin
                    r_chg <= 1'b0;
                    if (w_wr_bank && w_off == c_K) begin
                        r_val <= din;
                        r_chg <= (din != r_val);
                    end
                end
            end

            assign options[8*k +: 8] = r_val;
            assign opt_changed[k]    = r_chg;
        end
    endgenerate

    always_comb begin
        w_rd_val = 8'hFF;
        for (int k = 0; k < NREGS; k++) begin
            if (w_off == 8'(k)) w_rd_val = options[8*k +: 8];
        end
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (zxuno_regrd) begin
            if (w_lock_hit) begin
                dout = w_state_rd;
                oe_n = 1'b0;
            end else if (w_in_bank) begin
                dout = w_rd_val;
                oe_n = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zxuno_option_bank.sv
`default_nettype none
//==============================================================================
//  Module   : tb_zxuno_option_bank
//  Purpose  : Self-checking bench for zxuno_option_bank (NREGS=2,
//             BASE_ADDR=8'h0E, RESET_VALUE=16'h3C00, LOCK_ADDR=8'h0D).
//             A reference model predicts every cycle's outputs into a queue;
//             a monitor pops and compares on the falling edge.
//             Honours OPTBANK_LOCK_EN the same way as the design.
//
//  Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
module tb_zxuno_option_bank;

    localparam int          NREGS = 2;
    localparam logic [7:0]  BASE  = 8'h0E;
    localparam logic [15:0] RSTV  = 16'h3C00;
    localparam logic [7:0]  LADDR = 8'h0D;
`ifdef OPTBANK_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  zxuno_addr = 8'h00;
    logic        zxuno_regrd = 1'b0;
    logic        zxuno_regwr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        oe_n;
    logic [15:0] options;
    logic [1:0]  opt_changed;
    logic        locked;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zxuno_option_bank #(
        .NREGS(NREGS), .BASE_ADDR(BASE), .RESET_VALUE(RSTV), .LOCK_ADDR(LADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr),
        .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .din(din),
        .dout(dout), .oe_n(oe_n), .options(options),
        .opt_changed(opt_changed), .locked(locked)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] options;
        logic [1:0]  chg;
        logic        locked;
        logic        oe_n;
        logic [7:0]  dout;
    } exp_t;

    exp_t exp_q[$];

    byte unsigned m_reg[NREGS];
    int           m_state;   // 0 unlocked, 1 locked, 2 key1
    bit           m_prev;
    bit [1:0]     m_chg;

    function automatic int bank_index(input logic [7:0] a);
        return (int'(a) - int'(BASE) + 256) % 256;
    endfunction

    task automatic model_step();
        bit acc;
        bit lhit;
        int k;
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_reg[i] = RSTV[8*i +: 8];
            m_state = 0;
            m_chg   = '0;
            m_prev  = 1'b1;
        end else begin
            m_chg  = '0;
            acc    = zxuno_regwr && !m_prev;
            m_prev = zxuno_regwr;
            if (acc) begin
                lhit = LOCK_EN && (zxuno_addr == LADDR);
                k    = bank_index(zxuno_addr);
                if (m_state == 2) begin
                    m_state = (lhit && din == 8'h5A) ? 0 : 1;
                end else if (lhit) begin
                    if (m_state == 0 && din == 8'hFF) m_state = 1;
                    else if (m_state == 1 && din == 8'hA5) m_state = 2;
                end else if (k < NREGS && m_state == 0) begin
                    if (m_reg[k] != din) m_chg[k] = 1'b1;
                    m_reg[k] = din;
                end
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        int   k;
        for (int i = 0; i < NREGS; i++) e.options[8*i +: 8] = m_reg[i];
        e.chg    = m_chg;
        e.locked = (m_state != 0);
        e.oe_n   = 1'b1;
        e.dout   = 8'hFF;
        k = bank_index(zxuno_addr);
        if (zxuno_regrd) begin
            if (LOCK_EN && zxuno_addr == LADDR) begin
                e.oe_n = 1'b0;
                e.dout = 8'(m_state);
            end else if (k < NREGS) begin
                e.oe_n = 1'b0;
                e.dout = m_reg[k];
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sb_options", options, e.options);
                cmp("sb_opt_changed", 16'(opt_changed), 16'(e.chg));
                cmp("sb_locked", 16'(locked), 16'(e.locked));
                cmp("sb_oe_n", 16'(oe_n), 16'(e.oe_n));
                cmp("sb_dout", 16'(dout), 16'(e.dout));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic rn, input logic [7:0] a, input logic rd,
                         input logic wr, input logic [7:0] d);
        @(posedge clk);
        model_step();
        #1;
        rst_n = rn; zxuno_addr = a; zxuno_regrd = rd; zxuno_regwr = wr; din = d;
        push_expect();
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] d);
        cycle(1'b1, a, 1'b0, 1'b1, d);
        cycle(1'b1, a, 1'b0, 1'b0, d);
    endtask

    task automatic read(input logic [7:0] a);
        cycle(1'b1, a, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int pulses;
        logic [7:0] a, d;
        logic [7:0] addrs[6];

        // Reset
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        cmp("reset_options", options, 16'h3C00);
        cmp("reset_locked", 16'(locked), 16'h0000);
        cmp("reset_oe_n", 16'(oe_n), 16'h0001);

        // Held strobe writes exactly once
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h0E, 1'b0, (i < 4), 8'h81);
            if (opt_changed[0]) pulses++;
        end
        cmp("held_wr_value", 16'(options[7:0]), 16'h0081);
        cmp("held_wr_pulses", 16'(pulses), 16'h0001);

        // Identical value gives no pulse
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h0E, 1'b0, (i == 0), 8'h81);
            if (opt_changed[0]) pulses++;
        end
        cmp("same_value_pulses", 16'(pulses), 16'h0000);

        // Strobe already high across reset release is not accepted
        cycle(1'b0, 8'h0E, 1'b0, 1'b1, 8'h77);
        cycle(1'b0, 8'h0E, 1'b0, 1'b1, 8'h77);
        repeat (3) cycle(1'b1, 8'h0E, 1'b0, 1'b1, 8'h77);
        cycle(1'b1, 8'h0E, 1'b0, 1'b0, 8'h77);
        cmp("strobe_over_reset", options, 16'h3C00);

        // Unmapped reads
        read(8'h10);
        cmp("rd_unmapped_oe_n", 16'(oe_n), 16'h0001);
        cmp("rd_unmapped_dout", 16'(dout), 16'h00FF);
        read(8'h0F);
        cmp("rd_reg1", 16'(dout), 16'h003C);

`ifdef OPTBANK_LOCK_EN
        write(8'h0D, 8'hFF);
        write(8'h0E, 8'h55);
        cmp("lock_locked", 16'(locked), 16'h0001);
        cmp("lock_reg0_kept", 16'(options[7:0]), 16'h0000);
        read(8'h0D);
        cmp("lock_rd_state", 16'(dout), 16'h0001);
        write(8'h0D, 8'hA5);
        write(8'h0D, 8'h5A);
        cmp("unlock_locked", 16'(locked), 16'h0000);
        write(8'h0F, 8'h12);
        cmp("unlock_reg1", 16'(options[15:8]), 16'h0012);
        write(8'h0D, 8'hFF);
        write(8'h0D, 8'hA5);
        write(8'h0E, 8'h00);
        write(8'h0D, 8'h5A);
        cmp("key_abort_locked", 16'(locked), 16'h0001);
        read(8'h0D);
        cmp("key_abort_state", 16'(dout), 16'h0001);
        cmp("key_abort_reg0", 16'(options[7:0]), 16'h0000);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
`else
        read(8'h0D);
        cmp("rd_lockaddr_oe_n", 16'(oe_n), 16'h0001);
        cmp("rd_lockaddr_dout", 16'(dout), 16'h00FF);
        write(8'h0D, 8'hFF);
        write(8'h0E, 8'h55);
        cmp("nolock_locked", 16'(locked), 16'h0000);
        cmp("nolock_reg0", 16'(options[7:0]), 16'h0055);
`endif

        // Randomized traffic
        addrs[0] = 8'h0C; addrs[1] = 8'h0D; addrs[2] = 8'h0E;
        addrs[3] = 8'h0F; addrs[4] = 8'h10; addrs[5] = 8'h0E;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = addrs[$urandom_range(0, 5)];
            case ($urandom_range(0, 4))
                0: d = 8'hFF;
                1: d = 8'hA5;
                2: d = 8'h5A;
                default: d = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 63) != 0), a, 1'($urandom), 1'($urandom), d);
        end

        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zxuno_option_bank.md
ZXUNO_OPTION_BANK -- requirements
Module: zxuno_option_bank

Interface
REQ-001 Parameter NREGS, default 2: number of 8-bit option registers, legal range 1..8.
REQ-002 Parameter BASE_ADDR, default 8'h0E: register k sits at address BASE_ADDR+k, for k=0..NREGS-1.
REQ-003 Parameter RESET_VALUE, default all zeros, width 8*NREGS: reset image; byte k is register k.
REQ-004 Parameter LOCK_ADDR, default 8'h0D: lock/unlock command address.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 zxuno_addr  input  8  ZX-Uno register-space address.
REQ-008 zxuno_regrd  input  1  read strobe, level.
REQ-009 zxuno_regwr  input  1  write strobe, level, may stay high for several cycles.
REQ-010 din  input  8  write data.
REQ-011 dout  output  8  read data, combinational.
REQ-012 oe_n  output  1  active-low read-data enable, combinational.
REQ-013 options  output  8*NREGS  live register contents; byte k is register k.
REQ-014 opt_changed  output  NREGS  one-cycle pulse per register whose value changed.
REQ-015 locked  output  1  high while the lock FSM is in LOCKED or KEY1.

Function
REQ-016 A write shall be accepted only on the first cycle zxuno_regwr is high after being low (registered edge detect); further high cycles are ignored.
REQ-017 An accepted write to BASE_ADDR+k while the FSM is UNLOCKED shall load din into register k at the same clock edge.
REQ-018 opt_changed[k] shall be high for exactly the one cycle after an accepted write that changed register k; a write of an identical value gives no pulse.
REQ-019 Addresses outside the bank and LOCK_ADDR shall cause no state change.
REQ-020 Lock FSM states: UNLOCKED, LOCKED, KEY1.
REQ-021 UNLOCKED: accepted write of 8'hFF to LOCK_ADDR -> LOCKED; any other value -> stay.
REQ-022 LOCKED: accepted write of 8'hA5 to LOCK_ADDR -> KEY1; any other value -> stay.
REQ-023 KEY1: next accepted write of 8'h5A to LOCK_ADDR -> UNLOCKED; any other accepted write to any address -> LOCKED.
REQ-024 In LOCKED and KEY1, writes to option registers shall be discarded, with no opt_changed pulse.
REQ-025 Read, with zxuno_regrd high at address BASE_ADDR+k: oe_n=0 and dout=register k.
REQ-026 Read, with zxuno_regrd high at LOCK_ADDR: oe_n=0 and dout={6'b0, state code}, where UNLOCKED=0, LOCKED=1, KEY1=2.
REQ-027 All other cases: oe_n=1 and dout=8'hFF.
REQ-028 If the address range BASE_ADDR..BASE_ADDR+NREGS-1 wraps past 8'hFF, addresses shall wrap modulo 256.
REQ-029 If LOCK_ADDR falls inside the bank, the lock function shall take priority for both read and write.

Reset
REQ-030 When rst_n=0 at a clock edge, register k shall load byte k of RESET_VALUE.
REQ-031 The same reset shall put the FSM in UNLOCKED, clear opt_changed, and clear the write-edge history so that a strobe already high is not accepted.
REQ-032 Reset shall take priority over a write in the same cycle, including a write in the middle of a key sequence.

Configuration
REQ-033 Macro OPTBANK_LOCK_EN defined: the lock FSM and LOCK_ADDR decoding shall be compiled in as specified above.
REQ-034 Macro OPTBANK_LOCK_EN undefined: locked shall be tied to 0, registers shall always be writable, and LOCK_ADDR shall behave as an unmapped address (oe_n=1, dout=8'hFF).

Verification
REQ-035 Reset with NREGS=2 and RESET_VALUE=16'h3C00 -> options=16'h3C00, locked=0, oe_n=1.
REQ-036 Hold zxuno_regwr high for 4 cycles writing 8'h81 to 8'h0E -> options[7:0]=8'h81 after the first edge; exactly one opt_changed[0] pulse.
REQ-037 Write 8'hFF to 8'h0D, then 8'h55 to 8'h0E -> locked=1 and register 0 unchanged; reading 8'h0D returns 8'h01.
REQ-038 While locked, write 8'hA5 then 8'h5A to 8'h0D -> locked=0; a following write of 8'h12 to 8'h0F loads 8'h12 into register 1.
REQ-039 While locked, write 8'hA5 to 8'h0D, then 8'h00 to 8'h0E, then 8'h5A to 8'h0D -> FSM stays LOCKED and register 0 is unchanged.
REQ-040 Read at 8'h10 -> oe_n=1 and dout=8'hFF; with the macro undefined, a read at 8'h0D also gives oe_n=1 and dout=8'hFF.
